// File: rtl/pot_dot_product_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pot_dot_product_sequencer                                                |
// | Streams activation/PoT-weight pairs, shift-multiplies and accumulates    |
// | VECTOR_LENGTH products into one signed sum behind valid/ready handshakes.|
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module pot_dot_product_sequencer #(
  parameter int WEIGHT_BIT_WIDTH = 4,
  parameter int INPUT_BIT_WIDTH  = 4,
  parameter int VECTOR_LENGTH    = 8,
  localparam int PROD_WIDTH = INPUT_BIT_WIDTH + ((1 << (WEIGHT_BIT_WIDTH - 1)) - 1) + 1,
  localparam int ACC_WIDTH  = PROD_WIDTH + $clog2(VECTOR_LENGTH)
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [INPUT_BIT_WIDTH-1:0]         in_data,
  input  logic [WEIGHT_BIT_WIDTH-1:0]        in_weight,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic signed [ACC_WIDTH-1:0]        out_sum,
  output logic                               busy
);

  localparam int CNT_WIDTH = $clog2(VECTOR_LENGTH);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(VECTOR_LENGTH - 1);

  typedef enum logic [1:0] {
    ST_ACCUM = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t                        state_q, state_d;
  logic [CNT_WIDTH-1:0]          cnt_q, cnt_d;
  logic signed [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic signed [PROD_WIDTH-1:0]  prod_q, prod_d;
  logic                          prod_v_q, prod_v_d;

  logic                          accept;
  logic [PROD_WIDTH-1:0]         prod_mag;

  assign accept   = in_valid && (state_q == ST_ACCUM);
  assign prod_mag = PROD_WIDTH'(in_data) << in_weight[WEIGHT_BIT_WIDTH-2:0];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      ST_ACCUM: begin
        in_ready = 1'b1;
        if (accept) begin
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            state_d = ST_DRAIN;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_DRAIN: state_d = ST_DONE;
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = ST_ACCUM;
      end
      default: state_d = ST_ACCUM;
    endcase
  end

  // Stage 1: sign-magnitude PoT multiply; prod_v is a one-cycle strobe per accept.
  always_comb begin
    prod_d   = prod_q;
    prod_v_d = accept;
    if (accept) begin
      prod_d = in_weight[WEIGHT_BIT_WIDTH-1] ? -$signed(prod_mag) : $signed(prod_mag);
    end
  end

  // Stage 2: prod_v is never set in DONE, so the handoff clear cannot race an add.
  always_comb begin
    acc_d = acc_q;
    if (state_q == ST_DONE && out_ready) begin
      acc_d = '0;
    end else if (prod_v_q) begin
      acc_d = acc_q + {{(ACC_WIDTH - PROD_WIDTH){prod_q[PROD_WIDTH-1]}}, prod_q};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_ACCUM;
      cnt_q    <= '0;
      acc_q    <= '0;
      prod_q   <= '0;
      prod_v_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      prod_q   <= prod_d;
      prod_v_q <= prod_v_d;
    end
  end

  assign out_sum = acc_q;
  assign busy    = (state_q != ST_ACCUM) || (cnt_q != '0) || prod_v_q;

endmodule
`default_nettype wire

// File: tb/tb_pot_dot_product_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_pot_dot_product_sequencer                                             |
// | Directed and randomized vectors checked against an arithmetic model.     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_pot_dot_product_sequencer;

  localparam int WBW  = 4;
  localparam int IBW  = 4;
  localparam int VL   = 8;
  localparam int ACCW = IBW + ((1 << (WBW - 1)) - 1) + 1 + $clog2(VL);

  logic                   clk;
  logic                   rst_n;
  logic                   in_valid;
  logic                   in_ready;
  logic [IBW-1:0]         in_data;
  logic [WBW-1:0]         in_weight;
  logic                   out_valid;
  logic                   out_ready;
  logic signed [ACCW-1:0] out_sum;
  logic                   busy;

  int n_checks;
  int n_fails;

  int vd[VL];
  int vw[VL];
  int vg[VL];

  pot_dot_product_sequencer #(
    .WEIGHT_BIT_WIDTH(WBW),
    .INPUT_BIT_WIDTH (IBW),
    .VECTOR_LENGTH   (VL)
  ) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_weight(in_weight),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum  (out_sum),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: product of an unsigned activation and a sign-magnitude PoT weight.
  function automatic longint pot_prod(input int d, input int w);
    longint m;
    m = longint'(d) << (w & ((1 << (WBW - 1)) - 1));
    return ((w >> (WBW - 1)) & 1) ? -m : m;
  endfunction

  function automatic longint model_sum();
    longint s = 0;
    for (int i = 0; i < VL; i++) s += pot_prod(vd[i], vw[i]);
    return s;
  endfunction

  // Called and returns at a negedge; the accept happens on the posedge in between.
  task automatic send(input int d, input int w);
    int guard = 0;
    in_valid  = 1'b1;
    in_data   = IBW'(d);
    in_weight = WBW'(w);
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) chk("in_ready_timeout", 0, 1);
    @(negedge clk);
    in_valid  = 1'b0;
    in_data   = IBW'($urandom);
    in_weight = WBW'($urandom);
  endtask

  task automatic run_vector(input string tag, input longint exp, input int hold,
                            input bit valid_in_hold);
    int lat = 0;
    longint held;
    out_ready = 1'b0;
    for (int i = 0; i < VL; i++) begin
      repeat (vg[i]) @(negedge clk);
      if (i > 0 && vg[i] > 0) chk({tag, "_busy_gap"}, longint'(busy), 1);
      send(vd[i], vw[i]);
      if (i == 0) chk({tag, "_busy_first"}, longint'(busy), 1);
    end
    chk({tag, "_drain_valid"}, longint'(out_valid), 0);
    while (!out_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_latency"}, lat, 1);
    chk({tag, "_sum"}, longint'(out_sum), exp);
    held = longint'(out_sum);
    for (int k = 0; k < hold; k++) begin
      if (valid_in_hold) begin
        in_valid = 1'b1;
        in_data  = IBW'($urandom);
        in_weight = WBW'($urandom);
      end
      @(negedge clk);
      chk({tag, "_hold_ready"}, longint'(in_ready), 0);
      chk({tag, "_hold_valid"}, longint'(out_valid), 1);
      chk({tag, "_hold_sum"}, longint'(out_sum), held);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_post_valid"}, longint'(out_valid), 0);
    chk({tag, "_post_ready"}, longint'(in_ready), 1);
    chk({tag, "_post_busy"}, longint'(busy), 0);
    chk({tag, "_post_sum"}, longint'(out_sum), 0);
  endtask

  task automatic fill(input int d, input int w);
    for (int i = 0; i < VL; i++) begin
      vd[i] = d;
      vw[i] = w;
      vg[i] = 0;
    end
  endtask

  initial begin
    n_checks  = 0;
    n_fails   = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_weight = '0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", longint'(in_ready), 1);
    chk("rst_out_valid", longint'(out_valid), 0);
    chk("rst_out_sum", longint'(out_sum), 0);
    chk("rst_busy", longint'(busy), 0);

    fill(15, 4'b0111);
    run_vector("max_pos", 15360, 0, 1'b0);
    fill(15, 4'b1111);
    run_vector("max_neg", -15360, 0, 1'b0);

    vd = '{3, 5, 1, 7, 2, 0, 15, 4};
    vw = '{4'b0010, 4'b1001, 4'b1000, 4'b0000, 4'b0011, 4'b0111, 4'b1010, 4'b0001};
    vg = '{0, 0, 3, 0, 0, 0, 0, 0};
    run_vector("mixed", -28, 0, 1'b0);

    fill(2, 4'b0001);
    run_vector("backpressure", 32, 10, 1'b1);
    fill(1, 4'b0000);
    run_vector("after_bp", 8, 0, 1'b0);

    for (int i = 0; i < 5; i++) send(int'($urandom_range(15)), int'($urandom_range(15)));
    chk("midrst_busy_before", longint'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", longint'(in_ready), 1);
    chk("midrst_out_valid", longint'(out_valid), 0);
    chk("midrst_busy", longint'(busy), 0);
    chk("midrst_out_sum", longint'(out_sum), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    fill(1, 4'b0001);
    run_vector("after_rst", 16, 0, 1'b0);

    for (int v = 0; v < 25; v++) begin
      for (int i = 0; i < VL; i++) begin
        vd[i] = int'($urandom_range(15));
        vw[i] = int'($urandom_range(15));
        vg[i] = ($urandom_range(3) == 0) ? int'($urandom_range(1, 3)) : 0;
      end
      run_vector("rand", model_sum(), int'($urandom_range(3)), $urandom_range(1) == 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pot_dot_product_sequencer.md
# pot_dot_product_sequencer

Sequential dot-product engine built around a power-of-two (PoT) shift multiplier. It accepts a stream of unsigned activation / sign-magnitude PoT weight pairs over a valid/ready handshake, one pair per cycle. Each pair is multiplied by a signed left shift, and `VECTOR_LENGTH` products are accumulated into one signed sum. The sum is presented on an output valid/ready handshake. It sits between the weight/activation fetch logic and the neuron activation stage.

## Interface

**Parameters**
- `WEIGHT_BIT_WIDTH`, default 4: weight width. The MSB is the sign (1 = negative); the lower bits are the shift amount.
- `INPUT_BIT_WIDTH`, default 4: unsigned activation width.
- `VECTOR_LENGTH`, default 8: pairs per dot product. Must be ≥ 2.
- Derived `PROD_WIDTH` = `INPUT_BIT_WIDTH` + (2^(`WEIGHT_BIT_WIDTH`-1) - 1) + 1. This is the signed product width.
- Derived `ACC_WIDTH` = `PROD_WIDTH` + clog2(`VECTOR_LENGTH`). This is the signed accumulator width.

**Ports**
- `clk`, input, 1: clock. All state changes on the rising edge.
- `rst_n`, input, 1: reset. Asynchronous, active-low.
- `in_valid`, input, 1: pair valid.
- `in_ready`, output, 1: the block can accept a pair.
- `in_data`, input, `INPUT_BIT_WIDTH`: unsigned activation.
- `in_weight`, input, `WEIGHT_BIT_WIDTH`: sign-magnitude PoT weight.
- `out_valid`, output, 1: `out_sum` holds a completed dot product.
- `out_ready`, input, 1: consumer accepts `out_sum`.
- `out_sum`, output, `ACC_WIDTH`, signed: dot-product result.
- `busy`, output, 1: high when at least one pair of the current vector has been accepted and the result has not yet been handed off.

## Operation

**Product**
- Zero-extend `in_data` to `PROD_WIDTH`.
- Left-shift it by `in_weight[WEIGHT_BIT_WIDTH-2:0]`.
- Negate (two's complement) if `in_weight` MSB = 1.
- Weight with sign = 1 and shift = 0 yields -`in_data`. There is no negative-zero special case.

**Accumulation**
- `ACC_WIDTH` is chosen so the sum can never overflow. No saturation or wrap handling is required.

**Pipeline**
- Stage 1 registers the product (`prod_q`, `prod_v`) on every accepted pair.
- Stage 2 adds `prod_q` to the accumulator whenever `prod_v` = 1.

**FSM states**
- ACCUM: `in_ready` = 1. An element counter (0..`VECTOR_LENGTH`-1) increments on each accept.
  - On accepting the element with counter = `VECTOR_LENGTH`-1, go to DRAIN and clear the counter.
- DRAIN: `in_ready` = 0. The final product is accumulated. Go to DONE unconditionally on the next edge.
- DONE: `out_valid` = 1 and `in_ready` = 0.
  - `out_sum` = the accumulator, held stable until handoff.
  - On `out_valid` && `out_ready`: clear the accumulator and go to ACCUM.

**Other rules**
- An accept is `in_valid` && `in_ready`. Idle cycles (`in_valid` = 0) in ACCUM leave the counter and accumulator unchanged and clear `prod_v`.
- `busy` = (state != ACCUM) || (counter != 0) || `prod_v`.
- `in_data` and `in_weight` are don't-care when `in_valid` = 0.

**Reset values (asynchronous, on `rst_n` = 0)**
- state = ACCUM, counter = 0, accumulator = 0, `prod_q` = 0, `prod_v` = 0.
- Outputs: `in_ready` = 1, `out_valid` = 0, `out_sum` = 0, `busy` = 0.
- Reset mid-vector or in DONE discards all partial and pending results. The next accepted pair starts a fresh vector.

## Timing

- Throughput: one pair per cycle in ACCUM. One vector every `VECTOR_LENGTH` + 2 cycles when `out_ready` is held high.
- Let edge E be the edge that accepts the last element:
  - E: state becomes DRAIN.
  - E+1: the final add completes and state becomes DONE, so `out_valid` is high in the cycle after E+1.
- Output handoff on edge H, when `out_valid` && `out_ready` are both high:
  - `out_valid` falls.
  - `in_ready` rises in the cycle after H.
  - No pair is accepted on the handoff edge itself.
- `out_ready` held low keeps `out_valid` = 1 and `out_sum` constant indefinitely. No back-pressure is needed on stage 1, because DRAIN empties it before DONE.
- `out_valid` must not depend combinationally on `out_ready`.
- `in_ready` must not depend combinationally on `in_valid`.

## Test plan

1. **Reset values.** Drive reset, then release. Required: `in_ready` = 1, `out_valid` = 0, `out_sum` = 0, `busy` = 0.
2. **Maximum positive.** Defaults; 8 consecutive pairs with `in_data` = 15 and `in_weight` = 4'b0111. Required: `out_sum` = 15360, with `out_valid` rising 2 edges after the 8th accept.
3. **Maximum negative.** Same as scenario 2 with `in_weight` = 4'b1111. Required: `out_sum` = -15360.
4. **Mixed signs with idle gaps.** Pairs, with `in_valid` dropped for 3 cycles between pairs 2 and 3:
   - (3, 0010)
   - (5, 1001)
   - (1, 1000)
   - (7, 0000)
   - (2, 0011)
   - (0, 0111)
   - (15, 1010)
   - (4, 0001)

   Required: `out_sum` = 12 - 10 - 1 + 7 + 16 + 0 - 60 + 8 = -28.
5. **Output back-pressure.** Hold `out_ready` = 0 for 10 cycles in DONE while `in_valid` = 1. Required: `in_ready` = 0 throughout, no accepts, `out_sum` stable. After handoff, the next vector (all (1, 0000)) gives `out_sum` = 8, with no carry-over from the previous result.
6. **Reset mid-vector.** Pulse `rst_n` low after 5 accepts, then send 8 pairs of (1, 0001). Required: `out_sum` = 16.
